// File: rtl/seq_restoring_divider.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
//
// state    | meaning
// S_IDLE   | waiting for start; results from the last operation held
// S_RUN    | one restoring iteration per edge; extra edge loads results (also the divide-by-zero path)
// S_FINISH | done pulse, results valid
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             dz_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_diff;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Restored P is always below the divisor, so only its WIDTH low bits need storing.
    always_comb begin
        p_shift = {p_r, q_r[WIDTH-1]};
        p_diff  = p_shift - {1'b0, d_r};
    end

`ifdef SEQ_DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;

    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
    // Divide by zero keeps the all-ones quotient regardless of operand signs.
    assign q_final = (q_neg && !dz_r) ? -q_r : q_r;
    assign r_final = r_neg ? -p_r : p_r;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_final = q_r;
    assign r_final = p_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            last        <= 1'b0;
            dz_r        <= 1'b0;
            q_r         <= '0;
            d_r         <= '0;
            p_r         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        d_r         <= dvs_mag;
                        cnt         <= CNT_INIT;
                        state       <= S_RUN;
`ifdef SEQ_DIV_SIGNED_EN
                        q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg       <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            // Skip the iterations; results are loaded on the next edge.
                            dz_r <= 1'b1;
                            q_r  <= '1;
                            p_r  <= dvd_mag;
                            last <= 1'b1;
                        end else begin
                            dz_r <= 1'b0;
                            q_r  <= dvd_mag;
                            p_r  <= '0;
                            last <= 1'b0;
                            busy <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (last) begin
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= dz_r;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        last        <= 1'b0;
                        state       <= S_FINISH;
                    end else begin
                        q_r <= {q_r[WIDTH-2:0], ~p_diff[WIDTH]};
                        p_r <= p_diff[WIDTH] ? p_shift[WIDTH-1:0] : p_diff[WIDTH-1:0];
                        if (cnt == '0)
                            last <= 1'b1;
                        else
                            cnt <= cnt - CNT_ONE;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule
